lag_stats: RTL and testbench

LAG_STATS -- requirements
Module: lag_stats

---
 rtl/lag_stats.sv | 198 +++++++++++++++++++
 tb/tb_lag_stats.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lag_stats.sv
// Display-lag meter: times starttrigger to photodiode rising edge, keeps min/max/8-sample
// running average, and publishes all four values as BCD through one shared double-dabble engine.
module lag_stats #(
  parameter int unsigned TICK_DIV = 10000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        starttrigger,
  input  logic        sensor,
  input  logic        clear,
  output logic [79:0] bcdcount,
  output logic        update
);

  localparam logic [16:0] LAG_MAX    = 17'd99999;
  localparam logic [19:0] BCD_NONE   = 20'h99999;
  localparam logic [79:0] BCD_RESET  = {BCD_NONE, 20'h00000, BCD_NONE, BCD_NONE};
  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, MEASURE, UPDATE, CONVERT, PUBLISH} state_t;

  state_t      state;
  logic        sync1, sync2, sync3;
  logic        capture;
  logic [15:0] presc;
  logic [16:0] lag;
  logic [16:0] sample;
  logic [16:0] min_v, max_v;
  logic [16:0] ring [8];
  logic [2:0]  wr_ptr;
  logic [19:0] sum;
  logic [3:0]  count;
  logic [1:0]  conv_idx;
  logic [4:0]  conv_cnt;
  logic [16:0] conv_bin;
  logic [19:0] conv_bcd;
  logic [19:0] conv_next;
  logic [16:0] conv_src;
  logic [19:0] cur_bcd, min_bcd, max_bcd, avg_bcd;

  // One double-dabble step: add 3 to every digit >= 5, then shift the next binary bit in.
  function automatic logic [19:0] dd_step(input logic [19:0] bcd, input logic bit_in);
    logic [19:0] adj;
    for (int d = 0; d < 5; d++) begin
      adj[d*4 +: 4] = (bcd[d*4 +: 4] >= 4'd5) ? bcd[d*4 +: 4] + 4'd3 : bcd[d*4 +: 4];
    end
    return {adj[18:0], bit_in};
  endfunction

  function automatic logic [16:0] avg_of(input logic [19:0] s, input logic [3:0] n);
    return (n == 4'd8) ? s[19:3] : LAG_MAX;
  endfunction

  function automatic logic [3:0] sat_count(input logic [3:0] n);
    return (n == 4'd8) ? 4'd8 : n + 4'd1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign capture = sync2 & ~sync3;

  always_comb begin
    case (conv_idx)
      2'd0:    conv_src = sample;
      2'd1:    conv_src = min_v;
      2'd2:    conv_src = max_v;
      default: conv_src = avg_of(sum, count);
    endcase
  end

  assign conv_next = dd_step(conv_bcd, conv_bin[16]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      presc    <= '0;
      lag      <= '0;
      sample   <= '0;
      min_v    <= LAG_MAX;
      max_v    <= '0;
      for (int i = 0; i < 8; i++) ring[i] <= '0;
      wr_ptr   <= '0;
      sum      <= '0;
      count    <= '0;
      conv_idx <= '0;
      conv_cnt <= '0;
      conv_bin <= '0;
      conv_bcd <= '0;
      cur_bcd  <= BCD_NONE;
      min_bcd  <= BCD_NONE;
      max_bcd  <= '0;
      avg_bcd  <= BCD_NONE;
      bcdcount <= BCD_RESET;
      update   <= 1'b0;
    end else begin
      update <= 1'b0;
      if (clear) begin
        // Clear wins over everything, including a same-cycle trigger.
        state    <= IDLE;
        presc    <= '0;
        lag      <= '0;
        min_v    <= LAG_MAX;
        max_v    <= '0;
        for (int i = 0; i < 8; i++) ring[i] <= '0;
        wr_ptr   <= '0;
        sum      <= '0;
        count    <= '0;
        conv_idx <= '0;
        conv_cnt <= '0;
        cur_bcd  <= BCD_NONE;
        min_bcd  <= BCD_NONE;
        max_bcd  <= '0;
        avg_bcd  <= BCD_NONE;
        bcdcount <= BCD_RESET;
        update   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (starttrigger) begin
              presc <= '0;
              lag   <= '0;
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (lag == LAG_MAX) begin
              cur_bcd <= BCD_NONE;
              state   <= PUBLISH;
            end else if (capture) begin
              sample <= lag;
              state  <= UPDATE;
            end else if (starttrigger) begin
              presc <= '0;
              lag   <= '0;
            end else if (presc == PRESC_LAST) begin
              presc <= '0;
              lag   <= lag + 17'd1;
            end else begin
              presc <= presc + 16'd1;
            end
          end
          UPDATE: begin
            if (sample < min_v) min_v <= sample;
            if (sample > max_v) max_v <= sample;
            // Unused ring slots hold 0, so the running sum needs no special case while filling.
            ring[wr_ptr] <= sample;
            wr_ptr       <= wr_ptr + 3'd1;
            sum          <= sum - 20'(ring[wr_ptr]) + 20'(sample);
            count        <= sat_count(count);
            conv_idx     <= '0;
            conv_cnt     <= '0;
            state        <= CONVERT;
          end
          CONVERT: begin
            if (conv_cnt == 5'd0) begin
              conv_bin <= conv_src;
              conv_bcd <= '0;
              conv_cnt <= 5'd1;
            end else begin
              conv_bin <= {conv_bin[15:0], 1'b0};
              conv_bcd <= conv_next;
              if (conv_cnt == 5'd17) begin
                case (conv_idx)
                  2'd0:    cur_bcd <= conv_next;
                  2'd1:    min_bcd <= conv_next;
                  2'd2:    max_bcd <= conv_next;
                  default: avg_bcd <= conv_next;
                endcase
                conv_cnt <= '0;
                if (conv_idx == 2'd3) state <= PUBLISH;
                else conv_idx <= conv_idx + 2'd1;
              end else begin
                conv_cnt <= conv_cnt + 5'd1;
              end
            end
          end
          PUBLISH: begin
            bcdcount <= {avg_bcd, max_bcd, min_bcd, cur_bcd};
            update   <= 1'b1;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lag_stats.sv
// Scoreboard bench for lag_stats: instance A (TICK_DIV=4) for timing, averaging, retrigger,
// clear and reset; instance B (TICK_DIV=2) for a measurement followed by a no-capture timeout.
module tb_lag_stats;

  localparam logic [79:0] BCD_RST = 80'h99999_00000_99999_99999;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic        a_rst_n = 1'b1, a_start = 1'b0, a_sensor = 1'b0, a_clear = 1'b0;
  logic        b_rst_n = 1'b1, b_start = 1'b0, b_sensor = 1'b0, b_clear = 1'b0;
  logic        a_upd, b_upd;
  logic [79:0] a_bcd, b_bcd;

  lag_stats #(.TICK_DIV(4)) dut_a (
    .clock(clock), .reset_n(a_rst_n), .starttrigger(a_start), .sensor(a_sensor),
    .clear(a_clear), .bcdcount(a_bcd), .update(a_upd));

  lag_stats #(.TICK_DIV(2)) dut_b (
    .clock(clock), .reset_n(b_rst_n), .starttrigger(b_start), .sensor(b_sensor),
    .clear(b_clear), .bcdcount(b_bcd), .update(b_upd));

  typedef struct { logic [79:0] bcd; int cyc; } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int errors = 0;

  task automatic check80(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin : mon_a
    exp_t e;
    if (a_upd === 1'b1) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_update: got update at cycle %0d expected none", cyc);
      end else begin
        e = qa.pop_front();
        check80("a_bcdcount", a_bcd, e.bcd);
        check_int("a_update_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clock) begin : mon_b
    exp_t e;
    if (b_upd === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_update: got update at cycle %0d expected none", cyc);
      end else begin
        e = qb.pop_front();
        check80("b_bcdcount", b_bcd, e.bcd);
        check_int("b_update_cycle", cyc, e.cyc);
      end
    end
  end

  // Reference statistics for instance A
  int m_min = 99999, m_max = 0, m_sum = 0, m_cnt = 0, m_ptr = 0;
  int m_ring [8] = '{default: 0};
  int t_a, t_b;

  function automatic logic [19:0] bcd5(input int v);
    logic [19:0] r;
    int x;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_clear();
    m_min = 99999; m_max = 0; m_sum = 0; m_cnt = 0; m_ptr = 0;
    for (int i = 0; i < 8; i++) m_ring[i] = 0;
  endtask

  task automatic model_add(input int s, output logic [79:0] e);
    int avg;
    m_sum = m_sum - m_ring[m_ptr] + s;
    m_ring[m_ptr] = s;
    m_ptr = (m_ptr + 1) % 8;
    if (m_cnt < 8) m_cnt++;
    if (s < m_min) m_min = s;
    if (s > m_max) m_max = s;
    avg = (m_cnt == 8) ? m_sum / 8 : 99999;
    e = {bcd5(avg), bcd5(m_max), bcd5(m_min), bcd5(s)};
  endtask

  task automatic trigger_a();
    @(negedge clock);
    a_start = 1'b1;
    t_a = cyc + 1;
    @(negedge clock);
    a_start = 1'b0;
  endtask

  // Sensor raised just after edge d following the trigger is captured at edge d+3, where the
  // lag counter holds (d+2)/4; d = 4*s-2 therefore yields sample s.
  task automatic meas_a(input int s, input bit complete);
    int d, cap;
    exp_t x;
    trigger_a();
    d = 4 * s - 2;
    cap = t_a + d + 3;
    if (complete) begin
      model_add(s, x.bcd);
      x.cyc = cap + 74;
      qa.push_back(x);
    end
    while (cyc < t_a + d) @(negedge clock);
    a_sensor = 1'b1;
    while (cyc < cap) @(negedge clock);
    a_sensor = 1'b0;
    if (complete) while (cyc < cap + 78) @(negedge clock);
    else while (cyc < cap + 10) @(negedge clock);
  endtask

  initial begin
    int cap;
    exp_t x;
    #1;
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    repeat (3) @(negedge clock);
    check80("a_reset_bcd", a_bcd, BCD_RST);
    check80("a_reset_update", 80'(a_upd), 80'd0);
    check80("b_reset_bcd", b_bcd, BCD_RST);
    check80("b_reset_update", 80'(b_upd), 80'd0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    repeat (3) @(negedge clock);

    // Timing (sensor 40 cycles after trigger -> S=10) then averaging over 10..90
    for (int s = 10; s <= 90; s += 10) begin
      meas_a(s, 1'b1);
      if (s == 10) check80("a_first_sample", a_bcd, 80'h99999_00010_00010_00010);
      if (s == 80) check80("a_eight_samples", a_bcd, 80'h00045_00080_00010_00080);
      if (s == 90) check80("a_nine_samples", a_bcd, 80'h00055_00090_00010_00090);
      repeat (4) @(negedge clock);
    end

    // Retrigger: the second trigger restarts the count
    trigger_a();
    repeat (20) @(negedge clock);
    meas_a(5, 1'b1);
    check80("a_retrigger", a_bcd, 80'h00053_00090_00005_00005);
    repeat (4) @(negedge clock);

    // Clear coincident with trigger while converting
    meas_a(8, 1'b0);
    a_clear = 1'b1;
    a_start = 1'b1;
    x.bcd = BCD_RST;
    x.cyc = cyc + 1;
    qa.push_back(x);
    model_clear();
    @(negedge clock);
    a_clear = 1'b0;
    a_start = 1'b0;
    repeat (3) @(negedge clock);
    a_sensor = 1'b1;
    repeat (10) @(negedge clock);
    a_sensor = 1'b0;
    repeat (150) @(negedge clock);
    check_int("a_clear_pending", qa.size(), 0);
    check80("a_after_clear", a_bcd, BCD_RST);
    meas_a(30, 1'b1);
    check80("a_post_clear_meas", a_bcd, 80'h99999_00030_00030_00030);
    repeat (4) @(negedge clock);

    // Reset while converting
    meas_a(12, 1'b0);
    a_rst_n = 1'b0;
    #1;
    check80("a_midconv_reset_bcd", a_bcd, BCD_RST);
    check80("a_midconv_reset_update", 80'(a_upd), 80'd0);
    repeat (3) @(negedge clock);
    a_rst_n = 1'b1;
    model_clear();
    repeat (100) @(negedge clock);
    meas_a(40, 1'b1);
    check80("a_post_reset_meas", a_bcd, 80'h99999_00040_00040_00040);

    // Instance B: one measurement (S=7), then sensor high before trigger -> timeout
    @(negedge clock);
    b_start = 1'b1;
    t_b = cyc + 1;
    @(negedge clock);
    b_start = 1'b0;
    cap = t_b + 15;
    x.bcd = 80'h99999_00007_00007_00007;
    x.cyc = cap + 74;
    qb.push_back(x);
    while (cyc < t_b + 12) @(negedge clock);
    b_sensor = 1'b1;
    while (cyc < cap) @(negedge clock);
    b_sensor = 1'b0;
    while (cyc < cap + 78) @(negedge clock);
    check80("b_first_meas", b_bcd, 80'h99999_00007_00007_00007);

    b_sensor = 1'b1;
    repeat (10) @(negedge clock);
    @(negedge clock);
    b_start = 1'b1;
    t_b = cyc + 1;
    @(negedge clock);
    b_start = 1'b0;
    x.bcd = 80'h99999_00007_00007_99999;
    x.cyc = t_b + 99999 * 2 + 2;
    qb.push_back(x);
    while (cyc < t_b + 200010) @(negedge clock);
    check80("b_timeout_bcd", b_bcd, 80'h99999_00007_00007_99999);
    b_sensor = 1'b0;

    repeat (5) @(negedge clock);
    check_int("a_queue_drained", qa.size(), 0);
    check_int("b_queue_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
